serial_byte_deser: RTL and testbench

Serial-to-parallel front end that feeds the team's 8-bit holding register. It receives an asynchronous-style framed bit stream (start bit, WIDTH data bits LSB first, optional parity, stop bit), one bit per `bit_en` strobe. It presents the assembled word on `OUT` with a one-cycle `valid` pulse, which the downstream register uses as its load enable.

---
 rtl/serial_pkg.sv | 14 +
 rtl/deser_shifter.sv | 40 ++++
 rtl/serial_byte_deser.sv | 119 +++++++++++
 tb/tb_serial_byte_deser.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial byte deserializer.
package serial_pkg;

   localparam int   SERIAL_DATA_WIDTH = 8;
   localparam logic SERIAL_IDLE_LEVEL = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } deser_state_t;

endpackage

// File: rtl/deser_shifter.sv
// Datapath for the deserializer: LSB-first shift register, bit counter and
// running even-parity accumulator.
module deser_shifter
   import serial_pkg::*;
#(
   parameter int WIDTH = SERIAL_DATA_WIDTH
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic             shift_en,
   input  logic             sin,
   output logic [WIDTH-1:0] data,
   output logic             parity,
   output logic             last_bit
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [CW-1:0] count;

   // New bits enter at the MSB so that after WIDTH shifts the first bit sits at bit 0.
   always_ff @(posedge clk) begin
      if (clear) begin
         data   <= '0;
         count  <= '0;
         parity <= 1'b0;
      end else if (start) begin
         count  <= '0;
         parity <= 1'b0;
      end else if (shift_en) begin
         data   <= {sin, data[WIDTH-1:1]};
         parity <= parity ^ sin;
         count  <= count + CW'(1);
      end
   end

   assign last_bit = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_byte_deser.sv
// Framed serial-to-parallel receiver; parity bit support is compiled in with
// the SERIAL_DESER_PARITY_EN macro.
module serial_byte_deser
   import serial_pkg::*;
#(
   parameter int WIDTH = SERIAL_DATA_WIDTH
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             bit_en,
   input  logic             SIN,
   output logic [WIDTH-1:0] OUT,
   output logic             valid,
   output logic             busy,
   output logic             frame_err,
   output logic             parity_err
);

   deser_state_t     state;
   logic [WIDTH-1:0] shift_data;
   logic             parity_acc;
   logic             last_bit;
   logic             start_bit;
   logic             shift_en;
   logic             stop_parity_bad;

   assign start_bit = bit_en && (state == IDLE) && (SIN != SERIAL_IDLE_LEVEL);
   assign shift_en  = bit_en && (state == DATA);

   deser_shifter #(.WIDTH(WIDTH)) u_shifter (
      .clk      (clk),
      .clear    (clear),
      .start    (start_bit),
      .shift_en (shift_en),
      .sin      (SIN),
      .data     (shift_data),
      .parity   (parity_acc),
      .last_bit (last_bit)
   );

`ifdef SERIAL_DESER_PARITY_EN
   logic parity_bad;
   assign stop_parity_bad = parity_bad;
`else
   logic unused_parity;
   assign unused_parity   = parity_acc;
   assign stop_parity_bad = 1'b0;
   assign parity_err      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (clear) begin
         state     <= IDLE;
         OUT       <= '0;
         valid     <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
         parity_err <= 1'b0;
         parity_bad <= 1'b0;
`endif
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (bit_en) begin
            case (state)
               IDLE: begin
                  if (start_bit) begin
                     state <= DATA;
                     busy  <= 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
                     parity_bad <= 1'b0;
`endif
                  end
               end
               DATA: begin
                  if (last_bit) begin
`ifdef SERIAL_DESER_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
               PARITY: begin
`ifdef SERIAL_DESER_PARITY_EN
                  parity_bad <= parity_acc ^ SIN;
                  state      <= STOP;
`else
                  state <= IDLE;
                  busy  <= 1'b0;
`endif
               end
               STOP: begin
                  // A bad stop bit masks any parity result for this frame.
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (SIN == SERIAL_IDLE_LEVEL) begin
                     if (stop_parity_bad) begin
`ifdef SERIAL_DESER_PARITY_EN
                        parity_err <= 1'b1;
`endif
                     end else begin
                        OUT   <= shift_data;
                        valid <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_byte_deser.sv
// Directed bench for serial_byte_deser with a pulse scoreboard; parity cases
// run when SERIAL_DESER_PARITY_EN is defined.
module tb_serial_byte_deser;

   localparam int WIDTH = 8;
`ifdef SERIAL_DESER_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 3;
`else
   localparam int FRAME_LEN = WIDTH + 2;
`endif

   typedef struct {
      logic [2:0]       kind;
      logic [WIDTH-1:0] out;
   } exp_t;

   logic             clk;
   logic             clear;
   logic             bit_en;
   logic             SIN;
   logic [WIDTH-1:0] OUT;
   logic             valid;
   logic             busy;
   logic             frame_err;
   logic             parity_err;

   int               checks = 0;
   int               fails  = 0;
   int               cycle_cnt = 0;
   int               valid_times[$];
   exp_t             sb[$];
   logic [WIDTH-1:0] model_out = '0;

   serial_byte_deser #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .clear      (clear),
      .bit_en     (bit_en),
      .SIN        (SIN),
      .OUT        (OUT),
      .valid      (valid),
      .busy       (busy),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every pulse must match the oldest outstanding expectation, including the held OUT value.
   always @(negedge clk) begin
      exp_t e;
      cycle_cnt++;
      if (valid || frame_err || parity_err) begin
         if (valid) valid_times.push_back(cycle_cnt);
         checks++;
         assert (sb.size() > 0)
            else begin
               fails++;
               $error("FAIL unexpected_pulse: observed pulses %b, expected none pending", {parity_err, frame_err, valid});
            end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert ({parity_err, frame_err, valid, OUT} === {e.kind, e.out})
               else begin
                  fails++;
                  $error("FAIL pulse_out: observed pulses %b OUT 0x%0h, expected pulses %b OUT 0x%0h",
                         {parity_err, frame_err, valid}, OUT, e.kind, e.out);
               end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         end
   endtask

   task automatic sendBit(input logic b, input int spacing);
      SIN    = b;
      bit_en = 1'b1;
      @(posedge clk);
      #1;
      bit_en = 1'b0;
      repeat (spacing - 1) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic flip,
                                input logic stop_bit, input int spacing);
      exp_t e;
      if (!stop_bit) e = '{3'b010, model_out};
`ifdef SERIAL_DESER_PARITY_EN
      else if (flip) e = '{3'b100, model_out};
`endif
      else begin
         model_out = data;
         e = '{3'b001, data};
      end
      sb.push_back(e);
      sendBit(1'b0, spacing);
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      for (int i = 0; i < WIDTH; i++) sendBit(data[i], spacing);
`ifdef SERIAL_DESER_PARITY_EN
      sendBit((^data) ^ flip, spacing);
`else
      if (flip) $display("[TB] parity flip ignored in this build");
`endif
      sendBit(stop_bit, spacing);
   endtask

   initial begin
      clear  = 1'b1;
      bit_en = 1'b0;
      SIN    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      clear = 1'b0;
      checkOutput("reset_out", 32'(OUT), 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_pulses", 32'({parity_err, frame_err, valid}), 32'd0);

      $display("[TB] idle line with bit_en held high");
      SIN    = 1'b1;
      bit_en = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      bit_en = 1'b0;
      checkOutput("idle_out", 32'(OUT), 32'h0);
      checkOutput("idle_busy", 32'(busy), 32'd0);

      $display("[TB] frame 0xA5 with continuous strobes");
      applyStimulus(8'hA5, 1'b0, 1'b1, 1);
      checkOutput("a5_valid_pulse", 32'(valid), 32'd1);
      checkOutput("a5_out", 32'(OUT), 32'hA5);
      checkOutput("a5_busy_low", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("a5_valid_one_cycle", 32'(valid), 32'd0);

      $display("[TB] frame 0xA5 with bad stop bit");
      applyStimulus(8'hA5, 1'b0, 1'b0, 1);
      checkOutput("ferr_pulse", 32'(frame_err), 32'd1);
      checkOutput("ferr_no_valid", 32'(valid), 32'd0);
      checkOutput("ferr_out_held", 32'(OUT), 32'hA5);
      @(posedge clk);
      #1;
      checkOutput("ferr_one_cycle", 32'(frame_err), 32'd0);

      $display("[TB] back-to-back frames every 4th cycle");
      SIN = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      applyStimulus(8'h3C, 1'b0, 1'b1, 4);
      applyStimulus(8'hFF, 1'b0, 1'b1, 4);
      checkOutput("b2b_out", 32'(OUT), 32'hFF);
      checkOutput("b2b_gap",
                  (valid_times.size() >= 2) ?
                     32'(valid_times[valid_times.size()-1] - valid_times[valid_times.size()-2]) : 32'd0,
                  32'(FRAME_LEN * 4));

      $display("[TB] clear after four data bits");
      sendBit(1'b0, 1);
      for (int i = 0; i < 4; i++) sendBit(1'b1, 1);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear     = 1'b0;
      model_out = '0;
      checkOutput("abort_out", 32'(OUT), 32'h0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_pulses", 32'({parity_err, frame_err, valid}), 32'd0);
      applyStimulus(8'h81, 1'b0, 1'b1, 1);
      checkOutput("after_abort_out", 32'(OUT), 32'h81);

      $display("[TB] stop bit followed immediately by a start bit");
      applyStimulus(8'h5A, 1'b0, 1'b1, 1);
      applyStimulus(8'hC3, 1'b0, 1'b1, 1);
      checkOutput("tight_b2b_out", 32'(OUT), 32'hC3);

`ifdef SERIAL_DESER_PARITY_EN
      $display("[TB] parity good and bad frames");
      applyStimulus(8'hA5, 1'b0, 1'b1, 1);
      checkOutput("par_ok_out", 32'(OUT), 32'hA5);
      applyStimulus(8'h3C, 1'b1, 1'b1, 2);
      checkOutput("par_bad_out_held", 32'(OUT), 32'hA5);
      applyStimulus(8'h3C, 1'b1, 1'b0, 1);
      checkOutput("par_bad_ferr_only", 32'({parity_err, frame_err}), 32'd1);
`endif

      SIN = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      checkOutput("final_pulses", 32'({parity_err, frame_err, valid}), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
